mio_bus_responder: RTL and testbench

Memory/IO responder that sits on the far side of the multicycle CPU's memory port. It accepts one word access at a time (address, write data, read/write strobe) and serves it from an internal word RAM or one of three memory-mapped peripheral registers. Each access completes after a programmable number of wait states, and the block returns read data plus ready/acknowledge status. It drives the CPU's `MIO_ready` and `data2CPU` inputs.

---
 rtl/mio_bus_responder.sv | 143 ++++++++++++++
 tb/tb_mio_bus_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_responder.sv
// Single-outstanding memory/IO responder: word RAM, LED, switch and cycle-counter registers.
// Each access takes WAIT_CYCLES wait states plus one DONE cycle; MIO_ready is low while waiting.
module mio_bus_responder #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_w,
  input  logic [31:0] M_addr,
  input  logic [31:0] data_out,
  input  logic [15:0] sw,
  output logic [31:0] data2CPU,
  output logic        MIO_ready,
  output logic        mem_ack,
  output logic [15:0] led
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [29:0] LED_WA    = 30'h3C00_0000;
  localparam logic [29:0] SW_WA     = 30'h3C00_0001;
  localparam logic [29:0] CNT_WA    = 30'h3C00_0002;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [29:0] addr_q;
  logic        w_q;
  logic [31:0] wdata_q;
  logic [31:0] cycle_cnt;
  logic [31:0] ram [2**RAM_AW];

  logic              commit;
  logic [29:0]       acc_addr;
  logic              acc_w;
  logic [31:0]       acc_wdata;
  logic [RAM_AW-1:0] ram_idx;
  logic              is_ram, is_led, is_sw, is_cnt;
  logic [31:0]       rd_mux;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^M_addr[1:0];

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    commit       = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_req) begin
          if (NO_WAIT) begin
            state_nxt = S_DONE;
            commit    = 1'b1;
          end else begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = S_DONE;
          commit    = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the capture edge, so use the live request.
  always_comb begin
    acc_addr  = addr_q;
    acc_w     = w_q;
    acc_wdata = wdata_q;
    if (state == S_IDLE) begin
      acc_addr  = M_addr[31:2];
      acc_w     = mem_w;
      acc_wdata = data_out;
    end
  end

  assign ram_idx = acc_addr[RAM_AW-1:0];
  assign is_ram  = (acc_addr[29:RAM_AW] == '0);
  assign is_led  = (acc_addr == LED_WA);
  assign is_sw   = (acc_addr == SW_WA);
  assign is_cnt  = (acc_addr == CNT_WA);

  always_comb begin
    rd_mux = 32'h0;
    if (is_ram)      rd_mux = ram[ram_idx];
    else if (is_led) rd_mux = {16'h0, led};
    else if (is_sw)  rd_mux = {16'h0, sw};
    else if (is_cnt) rd_mux = cycle_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      addr_q    <= 30'h0;
      w_q       <= 1'b0;
      wdata_q   <= 32'h0;
      MIO_ready <= 1'b1;
      mem_ack   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      MIO_ready <= (state_nxt != S_WAIT);
      mem_ack   <= (state_nxt == S_DONE);
      if (state == S_IDLE && mem_req) begin
        addr_q  <= M_addr[31:2];
        w_q     <= mem_w;
        wdata_q <= data_out;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data2CPU  <= 32'h0;
      led       <= 16'h0;
      cycle_cnt <= 32'h0;
    end else begin
      if (commit && !acc_w) data2CPU <= rd_mux;
      if (commit && acc_w && is_led) led <= acc_wdata[15:0];
      // A counter load wins over the free-running increment.
      if (commit && acc_w && is_cnt) cycle_cnt <= acc_wdata;
      else                           cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // RAM has no reset; the reset term keeps a zero-wait request from writing while held in reset.
  always_ff @(posedge clk) begin
    if (commit && acc_w && is_ram && !reset) ram[ram_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
module tb_mio_bus_responder;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_w;
  logic [31:0] M_addr, data_out;
  logic [15:0] sw;
  logic [31:0] data2CPU;
  logic        MIO_ready, mem_ack;
  logic [15:0] led;

  logic        req0, w0;
  logic [31:0] addr0, dout0;
  logic [31:0] rd0;
  logic        rdy0, ack0;
  logic [15:0] led0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy0_low = 0;

  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_w(mem_w), .M_addr(M_addr),
    .data_out(data_out), .sw(sw), .data2CPU(data2CPU), .MIO_ready(MIO_ready),
    .mem_ack(mem_ack), .led(led)
  );

  mio_bus_responder #(.RAM_AW(4), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .mem_req(req0), .mem_w(w0), .M_addr(addr0),
    .data_out(dout0), .sw(sw), .data2CPU(rd0), .MIO_ready(rdy0),
    .mem_ack(ack0), .led(led0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rdy0) rdy0_low++;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after an edge with the main DUT idle; returns #1 after the edge leaving DONE.
  task automatic do_access(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int commit_cyc);
    int n, low;
    mem_req  = 1'b1;
    mem_w    = w;
    M_addr   = addr;
    data_out = wd;
    @(posedge clk); #1;
    mem_req  = 1'b0;
    mem_w    = ~w;
    M_addr   = $urandom;
    data_out = $urandom;
    n = 0;
    low = 0;
    while (!mem_ack && n < 20) begin
      if (!MIO_ready) low++;
      @(posedge clk); #1;
      n++;
    end
    check("ack_latency", n, WAIT);
    check("ready_low_cycles", low, WAIT);
    check("ready_in_done", {31'h0, MIO_ready}, 32'h1);
    rd = data2CPU;
    commit_cyc = cyc;
    @(posedge clk); #1;
    check("ack_one_cycle", {31'h0, mem_ack}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    int wc, rc, acks;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 16'h0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 16'h0000};
    vecs[2]  = '{1'b1, 32'hF000_0000, 32'h1234_ABCD, 32'hDEAD_BEEF, 16'hABCD};
    vecs[3]  = '{1'b0, 32'hF000_0000, 32'h0,         32'h0000_ABCD, 16'hABCD};
    vecs[4]  = '{1'b0, 32'hF000_0004, 32'h0,         32'h0000_5A5A, 16'hABCD};
    vecs[5]  = '{1'b1, 32'hF000_0004, 32'hFFFF_FFFF, 32'h0000_5A5A, 16'hABCD};
    vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0,         32'h0000_0000, 16'hABCD};
    vecs[7]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 32'h0000_0000, 16'hABCD};
    vecs[8]  = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 16'hABCD};
    vecs[9]  = '{1'b1, 32'h0000_1010, 32'h5555_5555, 32'hDEAD_BEEF, 16'hABCD};
    vecs[10] = '{1'b0, 32'h0000_1010, 32'h0,         32'h0000_0000, 16'hABCD};
    vecs[11] = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0000_0000, 16'hABCD};
    vecs[12] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hA5A5_A5A5, 16'hABCD};
    vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 16'hABCD};

    reset = 1'b1;
    mem_req = 1'b0; mem_w = 1'b0; M_addr = 32'h0; data_out = 32'h0;
    req0 = 1'b0; w0 = 1'b0; addr0 = 32'h0; dout0 = 32'h0;
    sw = 16'h5A5A;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, MIO_ready}, 32'h1);
    check("rst_ack", {31'h0, mem_ack}, 32'h0);
    check("rst_data", data2CPU, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    reset = 1'b0;

    // Zero-wait instance: the first edge after reset commits a counter read of 0.
    req0 = 1'b1; w0 = 1'b0; addr0 = 32'hF000_0008;
    @(posedge clk); #1;
    req0 = 1'b0;
    check("w0_first_cnt", rd0, 32'h0);
    check("w0_ack", {31'h0, ack0}, 32'h1);
    @(posedge clk); #1;
    req0 = 1'b1; w0 = 1'b1; addr0 = 32'h0000_003C; dout0 = 32'h0BAD_CAFE;
    @(posedge clk); #1;
    req0 = 1'b0;
    check("w0_wr_ack", {31'h0, ack0}, 32'h1);
    check("w0_wr_keeps_data", rd0, 32'h0);
    @(posedge clk); #1;
    req0 = 1'b1; w0 = 1'b0; addr0 = 32'h0000_003C;
    @(posedge clk); #1;
    req0 = 1'b0;
    check("w0_ram_read", rd0, 32'h0BAD_CAFE);
    @(posedge clk); #1;
    req0 = 1'b1; w0 = 1'b0; addr0 = 32'h0000_0040;
    @(posedge clk); #1;
    req0 = 1'b0;
    check("w0_unmapped_read", rd0, 32'h0);
    check("w0_unmapped_ack", {31'h0, ack0}, 32'h1);
    @(posedge clk); #1;
    check("w0_never_busy", rdy0_low, 0);

    foreach (vecs[i]) begin
      do_access(vecs[i].w, vecs[i].addr, vecs[i].wd, rd, wc);
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
    end

    // Counter loaded on edge wc; read committed at wc+6 sees the value held before that edge.
    do_access(1'b1, 32'hF000_0008, 32'hFFFF_FFFE, rd, wc);
    while (cyc < wc + 3) begin
      @(posedge clk); #1;
    end
    do_access(1'b0, 32'hF000_0008, 32'h0, rd, rc);
    check("cnt_commit_gap", rc - wc, 6);
    check("cnt_wrap_read", rd, 32'h0000_0003);

    // Reset during WAIT must abort the write.
    do_access(1'b1, 32'h0000_0010, 32'h2222_2222, rd, wc);
    mem_req = 1'b1; mem_w = 1'b1; M_addr = 32'h0000_0010; data_out = 32'h1111_1111;
    @(posedge clk); #1;
    mem_req = 1'b0;
    check("abort_in_wait", {31'h0, MIO_ready}, 32'h0);
    reset = 1'b1;
    #1;
    check("abort_rst_ready", {31'h0, MIO_ready}, 32'h1);
    check("abort_rst_data", data2CPU, 32'h0);
    check("abort_rst_led", {16'h0, led}, 32'h0);
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (mem_ack) acks++;
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (mem_ack) acks++;
    end
    check("abort_no_ack", acks, 0);
    do_access(1'b0, 32'h0000_0010, 32'h0, rd, rc);
    check("abort_ram_kept", rd, 32'h2222_2222);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
